// File: rtl/dqn_pkg.sv
// rtl/dqn_pkg.sv - layer codes, layer sizes and pass-tracking types for the target weight memory
package dqn_pkg;

  localparam int WEIGHT_COUNTER_WIDTH = 11;

  localparam logic [1:0] LAYER_NONE    = 2'b00;
  localparam logic [1:0] LAYER_HIDDEN1 = 2'b01;
  localparam logic [1:0] LAYER_HIDDEN2 = 2'b10;
  localparam logic [1:0] LAYER_OUTPUT  = 2'b11;

  localparam int DEF_INPUT  = 2;
  localparam int DEF_H1     = 32;
  localparam int DEF_H2     = 32;
  localparam int DEF_OUTPUT = 3;

  // Weights per layer include one bias term per node.
  function automatic int layer_size(input int fan_in, input int nodes);
    return nodes * (fan_in + 1);
  endfunction

  localparam int L1_SIZE       = layer_size(DEF_INPUT, DEF_H1);
  localparam int L2_SIZE       = layer_size(DEF_H1, DEF_H2);
  localparam int L3_SIZE       = layer_size(DEF_H2, DEF_OUTPUT);
  localparam int TOTAL_WEIGHTS = L1_SIZE + L2_SIZE + L3_SIZE;

  typedef enum logic {
    LOAD_IDLE,
    LOAD_LOADING
  } load_state_t;

endpackage

// File: rtl/dqn_weight_bank.sv
// rtl/dqn_weight_bank.sv - simple dual-port read-first weight RAM with two-cycle read
module dqn_weight_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 96,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_en_q;

  // Array access: the read samples the array before this edge's write lands, giving old data on a collision
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
  end

  // Output register, loaded only one cycle after an issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      rdata   <= '0;
    end else begin
      rd_en_q <= re;
      if (rd_en_q) rdata <= rd_q;
    end
  end

endmodule

// File: rtl/dqn_target_weight_memory.sv
// rtl/dqn_target_weight_memory.sv - DQN target weight store; DQN_WEIGHT_RANGE_CHECK_EN enables address range checks
module dqn_target_weight_memory
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = DEF_INPUT,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = DEF_H1,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = DEF_H2,
  parameter int NUMBER_OF_OUTPUT_NODE         = DEF_OUTPUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_weight_valid_request,
  input  logic [LAYER_WIDTH-1:0]          i_weight_layer_request,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr_request,
  output logic                            o_weight_valid,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0]           o_weight,
  input  logic                            i_update_weight_valid,
  input  logic [LAYER_WIDTH-1:0]          i_update_weight_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_update_weight_addr,
  input  logic [DATA_WIDTH-1:0]           i_update_weight,
  input  logic                            i_update_weight_done,
  output logic                            o_load_busy,
  output logic                            o_load_done,
  output logic                            o_load_ok,
  output logic                            o_addr_error
);

  localparam int L1    = layer_size(NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1);
  localparam int L2    = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2);
  localparam int L3    = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int TOTAL = L1 + L2 + L3;
  localparam int CW    = WEIGHT_COUNTER_WIDTH + 1;
  localparam int AW1   = $clog2(L1);
  localparam int AW2   = $clog2(L2);
  localparam int AW3   = $clog2(L3);

  localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  logic rd_range_ok, wr_range_ok;
  logic rd_accept, wr_accept;

`ifdef DQN_WEIGHT_RANGE_CHECK_EN
  function automatic logic in_range(input logic [LAYER_WIDTH-1:0] layer,
                                    input logic [WEIGHT_COUNTER_WIDTH-1:0] addr);
    logic [CW-1:0] a;
    a = {1'b0, addr};
    case (layer)
      LAYER_HIDDEN1: return a < CW'(L1);
      LAYER_HIDDEN2: return a < CW'(L2);
      LAYER_OUTPUT:  return a < CW'(L3);
      default:       return 1'b0;
    endcase
  endfunction

  assign rd_range_ok = in_range(i_weight_layer_request, i_weight_addr_request);
  assign wr_range_ok = in_range(i_update_weight_layer, i_update_weight_addr);
`else
  assign rd_range_ok = 1'b1;
  assign wr_range_ok = 1'b1;
`endif

  assign rd_accept = i_weight_valid_request && (i_weight_layer_request != LAYER_NONE) && rd_range_ok;
  assign wr_accept = i_update_weight_valid && (i_update_weight_layer != LAYER_NONE) && wr_range_ok;

  logic [DATA_WIDTH-1:0] rdata1, rdata2, rdata3;

  dqn_weight_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(L1), .ADDR_WIDTH(AW1)) u_bank_hidden1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept && (i_update_weight_layer == LAYER_HIDDEN1)),
    .waddr (i_update_weight_addr[AW1-1:0]),
    .wdata (i_update_weight),
    .re    (rd_accept && (i_weight_layer_request == LAYER_HIDDEN1)),
    .raddr (i_weight_addr_request[AW1-1:0]),
    .rdata (rdata1)
  );

  dqn_weight_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(L2), .ADDR_WIDTH(AW2)) u_bank_hidden2 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept && (i_update_weight_layer == LAYER_HIDDEN2)),
    .waddr (i_update_weight_addr[AW2-1:0]),
    .wdata (i_update_weight),
    .re    (rd_accept && (i_weight_layer_request == LAYER_HIDDEN2)),
    .raddr (i_weight_addr_request[AW2-1:0]),
    .rdata (rdata2)
  );

  dqn_weight_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(L3), .ADDR_WIDTH(AW3)) u_bank_output (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept && (i_update_weight_layer == LAYER_OUTPUT)),
    .waddr (i_update_weight_addr[AW3-1:0]),
    .wdata (i_update_weight),
    .re    (rd_accept && (i_weight_layer_request == LAYER_OUTPUT)),
    .raddr (i_weight_addr_request[AW3-1:0]),
    .rdata (rdata3)
  );

  logic                            v1;
  logic [LAYER_WIDTH-1:0]          layer1;
  logic [WEIGHT_COUNTER_WIDTH-1:0] addr1;

  // Two-stage tag pipeline that tracks the bank read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1             <= 1'b0;
      layer1         <= '0;
      addr1          <= '0;
      o_weight_valid <= 1'b0;
      o_weight_layer <= '0;
      o_weight_addr  <= '0;
    end else begin
      v1             <= rd_accept;
      layer1         <= i_weight_layer_request;
      addr1          <= i_weight_addr_request;
      o_weight_valid <= v1;
      o_weight_layer <= layer1;
      o_weight_addr  <= addr1;
    end
  end

  // Select the bank named by the echoed layer
  always_comb begin
    o_weight = '0;
    case (o_weight_layer)
      LAYER_HIDDEN1: o_weight = rdata1;
      LAYER_HIDDEN2: o_weight = rdata2;
      LAYER_OUTPUT:  o_weight = rdata3;
      default:       o_weight = '0;
    endcase
  end

  load_state_t   state;
  logic [CW-1:0] count, count_inc;

  assign count_inc = (wr_accept && (count != '1)) ? count + COUNT_ONE : count;

  // Pass tracking: count accepted writes, report on the updater's done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_IDLE;
      count       <= '0;
      o_load_busy <= 1'b0;
      o_load_done <= 1'b0;
      o_load_ok   <= 1'b0;
    end else begin
      o_load_done <= 1'b0;
      o_load_ok   <= 1'b0;
      if (i_update_weight_done) begin
        o_load_done <= 1'b1;
        o_load_ok   <= (state == LOAD_LOADING) && (count_inc == TOTAL_C);
        state       <= LOAD_IDLE;
        count       <= '0;
        o_load_busy <= 1'b0;
      end else if (wr_accept) begin
        state       <= LOAD_LOADING;
        count       <= count_inc;
        o_load_busy <= 1'b1;
      end
    end
  end

`ifdef DQN_WEIGHT_RANGE_CHECK_EN
  // Sticky record of any access dropped for an out-of-range address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_addr_error <= 1'b0;
    end else if ((i_weight_valid_request && (i_weight_layer_request != LAYER_NONE) && !rd_range_ok) ||
                 (i_update_weight_valid && (i_update_weight_layer != LAYER_NONE) && !wr_range_ok)) begin
      o_addr_error <= 1'b1;
    end
  end
`else
  assign o_addr_error = 1'b0;
`endif

endmodule

// File: doc/dqn_target_weight_memory.md
# dqn_target_weight_memory

Target-network weight store for the DQN core, sitting on the far side of the soft-update engine's request/update buffers. It answers that engine's weight read requests (layer, addr) with the stored target weight after a fixed latency, and absorbs its streamed write-back of blended weights into three per-layer RAMs. It counts each write-back pass and reports completion and integrity so the training controller can sequence the next episode.

## Interface
- DATA_WIDTH, 32, weight word width (IEEE-754 single)
- LAYER_WIDTH, 2, layer code width
- NUMBER_OF_INPUT_NODE, 2, network inputs
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden layer 1 nodes
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden layer 2 nodes
- NUMBER_OF_OUTPUT_NODE, 3, output nodes
- WEIGHT_COUNTER_WIDTH, 11, address width (localparam)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_weight_valid_request  in  1  read request strobe
- i_weight_layer_request  in  LAYER_WIDTH  layer of read
- i_weight_addr_request  in  WEIGHT_COUNTER_WIDTH  address of read
- o_weight_valid  out  1  read data valid
- o_weight_layer  out  LAYER_WIDTH  echoed layer
- o_weight_addr  out  WEIGHT_COUNTER_WIDTH  echoed address
- o_weight  out  DATA_WIDTH  read data
- i_update_weight_valid  in  1  write strobe
- i_update_weight_layer  in  LAYER_WIDTH  write layer
- i_update_weight_addr  in  WEIGHT_COUNTER_WIDTH  write address
- i_update_weight  in  DATA_WIDTH  write data
- i_update_weight_done  in  1  end-of-pass pulse from the updater
- o_load_busy  out  1  write-back pass in progress
- o_load_done  out  1  one-cycle pass-complete pulse
- o_load_ok  out  1  pass wrote exactly TOTAL words (valid with o_load_done)
- o_addr_error  out  1  sticky out-of-range flag (macro-gated)

## Operation
- Layer codes: 2'b01 hidden1 (size L1 = H1*(IN+1)), 2'b10 hidden2 (L2 = H2*(H1+1)), 2'b11 output (L3 = OUT*(H2+1)); TOTAL = L1+L2+L3 (96+1056+99 = 1251 at defaults).
- Read path: a request with layer 00 is dropped (no response); otherwise the selected bank is read and layer/addr are echoed alongside the data.
- Write path: a write with layer 00 is dropped, not counted; otherwise it is written to the bank, and the pass counter increments.
- Read and write fully independent, one each per cycle; same bank/address same cycle → read returns OLD data (read-first).
- Pass FSM: IDLE → LOADING on the first counted write (count=1). LOADING: count per write; on i_update_weight_done → IDLE, o_load_done=1 for one cycle, o_load_ok = (count==TOTAL), count cleared. A done pulse in IDLE still pulses o_load_done with o_load_ok=0. A done coinciding with a write counts that write first.
- o_load_busy = (state==LOADING).
- Counter width: WEIGHT_COUNTER_WIDTH+1; saturates at all-ones.
- RAM contents not reset; undefined until written.

## Timing
- Read latency 2 cycles: request at cycle N → o_weight_valid at N+2; back-to-back requests give back-to-back responses, order preserved.
- Write visible to a read issued one cycle after the write.
- o_load_done asserted the cycle after i_update_weight_done.
- Reset values: o_weight_valid 0, o_weight_layer 0, o_weight_addr 0, o_weight 0, o_load_busy 0, o_load_done 0, o_load_ok 0, o_addr_error 0; FSM IDLE, count 0; in-flight reads are discarded.
- Reset mid-pass abandons the pass; no o_load_done.

## Configuration
- DQN_WEIGHT_RANGE_CHECK_EN defined: read or write with addr ≥ its layer size is dropped (no response, no write, not counted) and o_addr_error sets, sticky until reset.
- Undefined: no checks, o_addr_error tied 0, out-of-range access behaviour unspecified.

## Structure
- dqn_pkg: layer code constants, per-layer size and TOTAL constants, WEIGHT_COUNTER_WIDTH.
- Sub-module dqn_weight_bank: simple dual-port, read-first RAM with registered address and output (2-cycle read), parameterised by depth; instantiated three times.

## Test plan
- Write hidden2 addr 5 = 0x3F800000, read it next cycle → o_weight 0x3F800000, layer 2'b10, addr 5 at +2 cycles.
- Same-cycle write 0x40000000 / read at output addr 0 holding 0x3F000000 → read returns 0x3F000000; next read returns 0x40000000.
- Full pass of 1251 writes then done pulse → o_load_done=1, o_load_ok=1 one cycle later; o_load_busy falls.
- Pass of 1250 writes then done → o_load_done=1, o_load_ok=0.
- With DQN_WEIGHT_RANGE_CHECK_EN, read hidden1 addr 96 → no o_weight_valid, o_addr_error=1 and stays 1.
- Assert rst_n low during a pass with 4 reads in flight → all outputs 0, no response emerges, next pass counts from 1.
